// File: rtl/mult_pkg.sv
// Shared types and constants for the 4x4 multiplier feeder.
// Holds the sequencer state encoding, operand/result widths and default timing values.
package mult_pkg;

    localparam int OP_W  = 4;
    localparam int RES_W = 8;

    localparam int FLUSH_CYCLES_DEF = 10;
    localparam int WAIT_TIMEOUT_DEF = 12;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Synchronous operand-pair FIFO; DEPTH must be a power of two so pointers wrap naturally.
// Pushes while full and pops while empty are ignored.
module mult_op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mult_feeder.sv
// Operand sequencer and result buffer in front of the reset-less 4x4 shift-add multiplier.
// Queues pairs, issues one St pulse per pair, holds operands, and captures the one-cycle Result.
module mult_feeder
    import mult_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int WAIT_TIMEOUT = WAIT_TIMEOUT_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [OP_W-1:0]  InA,
    input  logic [OP_W-1:0]  InB,
    output logic             St,
    output logic [OP_W-1:0]  Multiplier,
    output logic [OP_W-1:0]  Multiplicand,
    input  logic             Done,
    input  logic [RES_W-1:0] Result,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [RES_W-1:0] OutResult,
    output logic             Busy,
    output logic             Err,
    output state_t           DbgState
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and a raised valid holds its data until the transfer.

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam int WCW = $clog2(WAIT_TIMEOUT + 1);

    state_t              state;
    state_t              state_nxt;
    logic [FCW-1:0]      flush_cnt;
    logic [WCW-1:0]      wait_cnt;
    logic                flush_done;
    logic                wait_expired;
    logic                slot_free;
    logic                load_ops;
    logic                capture;
    logic                timeout;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_count;
    logic [2*OP_W-1:0]   fifo_head;

    assign InReady   = !fifo_full && (state != FLUSH);
    assign fifo_push = InValid && InReady;
    assign fifo_pop  = (state == ISSUE) && !fifo_empty;

    assign flush_done   = (flush_cnt == FCW'(FLUSH_CYCLES - 1));
    assign wait_expired = (wait_cnt == WCW'(WAIT_TIMEOUT - 1));
    // The slot may be reused in the same cycle its product is being taken.
    assign slot_free    = !OutValid || OutReady;

    assign Busy     = (state != IDLE);
    assign DbgState = state;

    mult_op_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * OP_W)
    ) u_fifo (
        .clk   (Clk),
        .rst   (Rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({InA, InB}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        load_ops  = 1'b0;
        capture   = 1'b0;
        timeout   = 1'b0;
        case (state)
            FLUSH: begin
                if (flush_done) state_nxt = IDLE;
            end
            IDLE: begin
                if ((fifo_count != '0) && slot_free) begin
                    state_nxt = ISSUE;
                    load_ops  = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (Done) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_expired) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = FLUSH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= FLUSH;
            flush_cnt    <= '0;
            wait_cnt     <= '0;
            St           <= 1'b0;
            Multiplier   <= '0;
            Multiplicand <= '0;
            OutValid     <= 1'b0;
            OutResult    <= '0;
            Err          <= 1'b0;
        end else begin
            state <= state_nxt;
            St    <= load_ops;

            if ((state == FLUSH) && !flush_done) flush_cnt <= flush_cnt + FCW'(1);

            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if ((state == WAIT) && !wait_expired) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end

            // Operands stay frozen until the next issue: the multiplier re-reads them mid-operation.
            if (load_ops) begin
                Multiplier   <= fifo_head[2*OP_W-1:OP_W];
                Multiplicand <= fifo_head[OP_W-1:0];
            end

            if (capture) begin
                OutResult <= Result;
                OutValid  <= 1'b1;
            end else if (OutValid && OutReady) begin
                OutValid <= 1'b0;
            end

            if (timeout) Err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_feeder.sv
// Directed bench for mult_feeder with a behavioural shift-add multiplier stub.
module tb_mult_feeder;
    import mult_pkg::*;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       InValid;
    logic       InReady;
    logic [3:0] InA;
    logic [3:0] InB;
    logic       St;
    logic [3:0] Multiplier;
    logic [3:0] Multiplicand;
    logic       Done = 1'b0;
    logic [7:0] Result = 8'h00;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] OutResult;
    logic       Busy;
    logic       Err;
    state_t     DbgState;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int st_cnt = 0;
    int done_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_t[$];

    logic       mbusy = 1'b0;
    int         mcnt = 0;
    logic [3:0] ma = 4'h0;
    logic       stub_dead = 1'b0;

    mult_feeder dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .InValid      (InValid),
        .InReady      (InReady),
        .InA          (InA),
        .InB          (InB),
        .St           (St),
        .Multiplier   (Multiplier),
        .Multiplicand (Multiplicand),
        .Done         (Done),
        .Result       (Result),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .OutResult    (OutResult),
        .Busy         (Busy),
        .Err          (Err),
        .DbgState     (DbgState)
    );

    // clock / reset
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // multiplier stub: Done 9 cycles after St, Multiplicand read at completion, garbage otherwise
    always @(posedge Clk) begin
        Done   <= 1'b0;
        Result <= 8'($urandom_range(0, 255));
        if (mbusy) begin
            mcnt <= mcnt + 1;
            if (mcnt == 8) begin
                mbusy <= 1'b0;
                if (!stub_dead) begin
                    Done     <= 1'b1;
                    Result   <= 8'(ma) * 8'(Multiplicand);
                    done_cnt <= done_cnt + 1;
                end
            end
        end else if (St) begin
            mbusy <= 1'b1;
            mcnt  <= 1;
            ma    <= Multiplier;
        end
    end

    // output monitor
    always @(posedge Clk) begin
        if (St) st_cnt <= st_cnt + 1;
        if (!Rst && OutValid && OutReady) begin
            got_q.push_back(OutResult);
            got_t.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic push(input logic [3:0] a, input logic [3:0] b);
        InValid = 1'b1;
        InA     = a;
        InB     = b;
        for (int i = 0; i < 200; i++) begin
            if (InReady) break;
            tick();
        end
        chk("push_ready", 32'(InReady), 32'd1);
        tick();
        InValid = 1'b0;
        exp_q.push_back(8'(a) * 8'(b));
    endtask

    task automatic wait_st();
        for (int i = 0; i < 40; i++) begin
            if (St) break;
            tick();
        end
        chk("st_seen", 32'(St), 32'd1);
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < 400; i++) begin
            if (got_q.size() >= n) break;
            tick();
        end
        chk("out_count", 32'(got_q.size()), 32'(n));
    endtask

    // scoreboard compare
    task automatic compare_all();
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk("product", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        chk("leftover_exp", 32'(exp_q.size()), 32'd0);
        chk("leftover_got", 32'(got_q.size()), 32'd0);
        exp_q.delete();
        got_q.delete();
        got_t.delete();
    endtask

    task automatic check_flush_window();
        logic seen_ready;
        seen_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (InReady) seen_ready = 1'b1;
            tick();
        end
        if (InReady) seen_ready = 1'b1;
        chk("flush_inready_low", 32'(seen_ready), 32'd0);
        tick();
        chk("flush_release_inready", 32'(InReady), 32'd1);
        chk("flush_release_state", 32'(DbgState), 32'(IDLE));
    endtask

    initial begin
        int c0;
        int t0;
        int s0;
        int d0;

        Rst      = 1'b1;
        InValid  = 1'b0;
        InA      = 4'h0;
        InB      = 4'h0;
        OutReady = 1'b1;

        // reset values
        tick();
        chk("rst_inready", 32'(InReady), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd1);
        chk("rst_st", 32'(St), 32'd0);
        chk("rst_outvalid", 32'(OutValid), 32'd0);
        chk("rst_outresult", 32'(OutResult), 32'd0);
        chk("rst_err", 32'(Err), 32'd0);
        chk("rst_mplier", 32'(Multiplier), 32'd0);
        chk("rst_mcand", 32'(Multiplicand), 32'd0);
        tick();
        tick();
        Rst = 1'b0;
        check_flush_window();

        // single pair 13*11, latency
        c0 = cyc;
        push(4'd13, 4'd11);
        chk("lat_st_n1", 32'(St), 32'd0);
        tick();
        chk("lat_st_n2", 32'(St), 32'd1);
        chk("lat_mplier", 32'(Multiplier), 32'd13);
        chk("lat_mcand", 32'(Multiplicand), 32'd11);
        chk("lat_state_issue", 32'(DbgState), 32'(ISSUE));
        tick();
        chk("lat_st_pulse", 32'(St), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        chk("lat_outvalid_n11", 32'(OutValid), 32'd0);
        tick();
        chk("lat_outvalid_n12", 32'(OutValid), 32'd1);
        chk("lat_outresult", 32'(OutResult), 32'h8F);
        collect(1);
        chk("lat_cycles", 32'(got_t[0] - c0), 32'd12);
        compare_all();

        // back-to-back throughput
        c0 = cyc;
        push(4'd15, 4'd15);
        push(4'd0, 4'd9);
        push(4'd1, 4'd1);
        push(4'd7, 4'd8);
        collect(4);
        if (got_t.size() == 4) begin
            chk("b2b_first", 32'(got_t[0] - c0), 32'd12);
            t0 = got_t[0];
            for (int i = 1; i < 4; i++) begin
                chk("b2b_spacing", 32'(got_t[i] - got_t[i-1]), 32'd11);
            end
        end
        compare_all();

        // FIFO full with a multiply in flight
        push(4'd2, 4'd5);
        wait_st();
        tick();
        push(4'd3, 4'd3);
        push(4'd4, 4'd4);
        push(4'd5, 4'd5);
        push(4'd6, 4'd6);
        chk("full_inready", 32'(InReady), 32'd0);
        chk("full_state", 32'(DbgState), 32'(WAIT));
        push(4'd7, 4'd7);
        collect(6);
        compare_all();

        // back-pressure
        OutReady = 1'b0;
        push(4'd15, 4'd15);
        push(4'd2, 4'd3);
        for (int i = 0; i < 60; i++) begin
            if (OutValid) break;
            tick();
        end
        chk("bp_outvalid", 32'(OutValid), 32'd1);
        chk("bp_result", 32'(OutResult), 32'd225);
        s0 = st_cnt;
        for (int i = 0; i < 30; i++) tick();
        chk("bp_hold_valid", 32'(OutValid), 32'd1);
        chk("bp_hold_result", 32'(OutResult), 32'd225);
        chk("bp_no_st", 32'(st_cnt), 32'(s0));
        chk("bp_state", 32'(DbgState), 32'(IDLE));
        OutReady = 1'b1;
        tick();
        chk("bp_st_after_ready", 32'(St), 32'd1);
        chk("bp_mplier", 32'(Multiplier), 32'd2);
        chk("bp_mcand", 32'(Multiplicand), 32'd3);
        chk("bp_slot_cleared", 32'(OutValid), 32'd0);
        collect(2);
        compare_all();

        // reset mid-multiply
        push(4'd9, 4'd9);
        void'(exp_q.pop_back());
        wait_st();
        for (int i = 0; i < 4; i++) tick();
        d0 = done_cnt;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("mrst_outvalid", 32'(OutValid), 32'd0);
        chk("mrst_mplier", 32'(Multiplier), 32'd0);
        chk("mrst_mcand", 32'(Multiplicand), 32'd0);
        chk("mrst_state", 32'(DbgState), 32'(FLUSH));
        chk("mrst_busy", 32'(Busy), 32'd1);
        check_flush_window();
        chk("mrst_done_in_flush", 32'(done_cnt - d0), 32'd1);
        chk("mrst_no_output", 32'(got_q.size()), 32'd0);
        push(4'd6, 4'd7);
        collect(1);
        compare_all();

        // missing Done -> sticky Err
        stub_dead = 1'b1;
        push(4'd3, 4'd5);
        void'(exp_q.pop_back());
        wait_st();
        for (int i = 0; i < 12; i++) tick();
        chk("to_err_before", 32'(Err), 32'd0);
        chk("to_state_wait", 32'(DbgState), 32'(WAIT));
        tick();
        chk("to_err_set", 32'(Err), 32'd1);
        chk("to_state_idle", 32'(DbgState), 32'(IDLE));
        chk("to_busy", 32'(Busy), 32'd0);
        chk("to_no_output", 32'(OutValid), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("to_err_sticky", 32'(Err), 32'd1);
        stub_dead = 1'b0;
        push(4'd2, 4'd2);
        collect(1);
        compare_all();
        chk("to_err_after_ok", 32'(Err), 32'd1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("to_err_cleared", 32'(Err), 32'd0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_feeder.md
# mult_feeder

Operand sequencer and result buffer that sits directly upstream of the 4×4 sequential shift-add multiplier. It queues operand pairs from a valid/ready producer and issues each pair with a one-cycle `St` pulse. It holds the operands stable for the whole multiply, captures `Result` in the single cycle `Done` is high, and presents the product on a valid/ready output. The block absorbs the multiplier's lack of a reset and its one-cycle-only result window.

## Interface
- `DEPTH`, default 4: operand FIFO entries; must be a power of 2, ≥2.
- `FLUSH_CYCLES`, default 10: post-reset cycles during which `St` is held low and `Done` is ignored.
- `WAIT_TIMEOUT`, default 12: maximum WAIT cycles before `Err` is raised.
- `Clk`  in  1  single clock; all logic on the rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `InValid`  in  1  operand pair offered.
- `InReady`  out  1  FIFO can accept a pair.
- `InA`  in  4  multiplier operand.
- `InB`  in  4  multiplicand operand.
- `St`  out  1  start pulse to the multiplier.
- `Multiplier`  out  4  registered operand to the multiplier.
- `Multiplicand`  out  4  registered operand to the multiplier.
- `Done`  in  1  multiplier completion, high for exactly one cycle.
- `Result`  in  8  multiplier product; valid only while `Done`=1.
- `OutValid`  out  1  product held in the output slot.
- `OutReady`  in  1  consumer accepts the product.
- `OutResult`  out  8  product.
- `Busy`  out  1  FSM in FLUSH, ISSUE or WAIT.
- `Err`  out  1  sticky; `Done` missing within `WAIT_TIMEOUT`.

## Operation
- FSM states and transitions:
  - FLUSH → IDLE when the flush counter reaches `FLUSH_CYCLES`−1. `InReady`=0 in FLUSH; `Done` is discarded.
  - IDLE → ISSUE when the FIFO is non-empty and the slot is free. The slot is free when `OutValid`=0, or when `OutValid`=1 and `OutReady`=1 in the same cycle. On this transition the FIFO head is loaded into `Multiplier`/`Multiplicand`.
  - ISSUE: `St`=1 for this cycle only. FIFO pops at the end of the cycle. → WAIT.
  - WAIT: `Result` is captured into `OutResult` and `OutValid` is set on the edge where `Done`=1, then → IDLE. If the wait counter reaches `WAIT_TIMEOUT`, set `Err` and go → IDLE with no output.
- `Multiplier`/`Multiplicand` stay constant from ISSUE until the next IDLE→ISSUE transition. The multiplier re-reads `Multiplicand` mid-operation, so these must not change during a multiply.
- FIFO behaviour:
  - `InReady` = (count < `DEPTH`) && state≠FLUSH.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo `DEPTH`.
- Output slot: `OutValid` clears on `OutValid`&&`OutReady`. A product is never overwritten, because issue is gated on the slot being free.
- `Done` outside WAIT is ignored.
- `Rst` (any state, including mid-multiply):
  - FIFO is emptied.
  - `OutValid`=0, `OutResult`=0, `Multiplier`=`Multiplicand`=0, `St`=0, `Err`=0.
  - State → FLUSH with counter=0.
  - FLUSH lets an in-flight multiply finish; its `Done` is dropped.
- Reset values: `InReady`=0, `Busy`=1, all other outputs 0.
- Arithmetic: none in this block. The product is unsigned 4×4→8, taken as-is from `Result`.

## Timing
- Reset release: the first cycle with `InReady`=1 is `FLUSH_CYCLES`+1 cycles after the last `Rst`=1 cycle.
- Latency: a pair accepted in cycle N (IDLE, FIFO empty) gives IDLE in N+1, `St`=1 in N+2, `Done` in N+11 and `OutValid`=1 in N+12. That is 12 cycles from handshake to output.
- Throughput: with `OutReady` held at 1, one product every 11 cycles (ISSUE, 9 WAIT cycles, IDLE).
- `St` always occurs while the multiplier is in its idle state: at least one IDLE cycle follows each `Done`.

## Structure
- Shared package `mult_pkg`, containing:
  - state enum {FLUSH, IDLE, ISSUE, WAIT};
  - `OP_W`=4 and `RES_W`=8;
  - the default `FLUSH_CYCLES` and `WAIT_TIMEOUT` values.
- Sub-module `mult_op_fifo`: synchronous FIFO, 8-bit wide ({A,B}), `DEPTH` entries, with push/pop/full/empty/count. The FSM, operand registers and output slot live in `mult_feeder`.
- Integration test instantiates `mult_feeder` connected to the existing multiplier.

## Test plan
- Reset release, then push A=13, B=11 → `St` one cycle in N+2; `OutValid`=1 with `OutResult`=0x8F (143) in N+12.
- Push 4 pairs back-to-back, `OutReady`=1: (15,15), (0,9), (1,1), (7,8) → products 225, 0, 1, 56 in order, spaced 11 cycles apart.
- FIFO full: push 5 pairs with `DEPTH`=4 while the first multiply is in flight → `InReady`=0 after the 4th pending entry; no pair is lost or duplicated.
- Back-pressure: `OutReady`=0 for 30 cycles after product 225 → `OutResult` holds 225; no `St` is issued; the next `St` comes in the IDLE cycle where `OutReady` rises.
- `Rst` pulsed 4 cycles after `St` → no output for that pair; `Done` during FLUSH is ignored; `InReady`=0 for 10 cycles; the next pair gives a correct product.
- Multiplier stub that never asserts `Done` → `Err`=1 after 12 WAIT cycles and stays high; state returns to IDLE; `Err` clears only on `Rst`.
